seq_tx: RTL and testbench
=========================

SEQ_TX -- requirements
Module: seq_tx

Interface
REQ-001 The block SHALL have parameter PAT_W, default 4, giving the pattern width in bits (range 2..16).
REQ-002 The block SHALL have parameter GAP, default 2, giving the idle cycles between repetitions (range 0..15).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  request to transmit in_pat/in_rep.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 in_pat  input  PAT_W  pattern to send, MSB first.
REQ-008 in_rep  input  4  repetition count minus one (0 = 1 transmission, 15 = 16).
REQ-009 abort  input  1  synchronous request to terminate the current frame.
REQ-010 dout  output  1  serial data bit.
REQ-011 dout_vld  output  1  dout carries a pattern bit this cycle.
REQ-012 busy  output  1  frame in progress.
REQ-013 done  output  1  one-cycle pulse marking the last bit of a frame.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SEND and GAPW.
REQ-015 in_ready SHALL be 1 iff state = IDLE and rst = 0; busy SHALL be 1 iff state != IDLE.
REQ-016 Acceptance SHALL occur on a rising edge with in_valid = 1 and in_ready = 1; in_pat and in_rep SHALL be latched at that edge.
REQ-017 On acceptance the state SHALL go to SEND, and dout SHALL present in_pat[PAT_W-1] with dout_vld = 1 in the cycle immediately following the edge (zero added latency; dout and dout_vld are registered).
REQ-018 In SEND, one bit SHALL be emitted per cycle, MSB to LSB, for PAT_W consecutive cycles.
REQ-019 After the LSB with repetitions remaining and GAP > 0, the state SHALL go to GAPW for exactly GAP cycles with dout = 0 and dout_vld = 0, then return to SEND starting again at the MSB.
REQ-020 After the LSB with repetitions remaining and GAP = 0, the next MSB SHALL follow in the very next cycle with no invalid cycle.
REQ-021 done SHALL be 1 only in the cycle carrying the LSB of the final repetition; the state SHALL be IDLE in the following cycle.
REQ-022 A frame SHALL occupy exactly (in_rep+1)*PAT_W + in_rep*GAP busy cycles.
REQ-023 in_valid while busy SHALL be ignored with no queueing; at least one IDLE cycle (in_ready = 1) SHALL separate consecutive frames.
REQ-024 dout SHALL be 0 whenever dout_vld = 0.
REQ-025 abort = 1 at a rising edge while busy SHALL force IDLE at that edge, with dout_vld = 0, busy = 0 and done = 0 in the next cycle; done SHALL NOT pulse for an aborted frame.
REQ-026 abort in IDLE SHALL have no effect; abort and acceptance at the same edge are impossible because abort is ignored in IDLE, so the acceptance SHALL proceed.
REQ-027 Bit and repetition counters SHALL be sized for PAT_W and 16 repetitions, and SHALL NOT wrap within a frame.

Reset
REQ-028 rst = 1 SHALL immediately, without a clock, force state IDLE, clear all counters and latched data, and set dout = 0, dout_vld = 0, busy = 0, done = 0 and in_ready = 0.
REQ-029 Reset asserted mid-frame SHALL discard the frame with no done pulse.
REQ-030 After rst falls, in_ready SHALL be 1, and a request SHALL be acceptable at the first rising edge.

Verification
REQ-031 The bench SHALL cover: assert rst between clock edges during SEND -> outputs 0 before the next edge; in_ready = 1 after release.
REQ-032 The bench SHALL cover: PAT_W = 4, GAP = 2, in_pat = 1001, in_rep = 0 -> dout 1,0,0,1 with dout_vld = 1 for 4 cycles, done = 1 on the 4th, in_ready = 1 on the 5th.
REQ-033 The bench SHALL cover: in_pat = 1001, in_rep = 2, GAP = 2 -> 1001, 00 (invalid), 1001, 00 (invalid), 1001; busy = 16 cycles; one done pulse.
REQ-034 The bench SHALL cover: GAP = 0, in_pat = 1011, in_rep = 1 -> 8 consecutive valid bits 10111011, done on the 8th.
REQ-035 The bench SHALL cover: in_valid held high with changing in_pat during a frame -> no effect; the next pattern is latched at the edge when in_ready = 1.
REQ-036 The bench SHALL cover: abort during the 2nd bit of a 3-repetition frame -> dout_vld = 0 and busy = 0 next cycle, no done, new request accepted the following edge.

Source files
------------

// File: rtl/seq_tx_if.sv
// ---------------------------------------------------------------------------
// seq_tx_if : request / serial-output bundle for seq_tx.
//
//   in_valid  request to transmit in_pat / in_rep      (master -> slave)
//   in_ready  slave can accept a request               (slave  -> master)
//   in_pat    pattern, sent MSB first                  (master -> slave)
//   in_rep    repetition count minus one               (master -> slave)
//   abort     terminate the frame in progress          (master -> slave)
//   dout      serial data bit                          (slave  -> master)
//   dout_vld  dout carries a pattern bit               (slave  -> master)
//   busy      frame in progress                        (slave  -> master)
//   done      pulse on the last bit of a frame         (slave  -> master)
// ---------------------------------------------------------------------------
interface seq_tx_if #(
    parameter int PAT_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [PAT_W-1:0] in_pat;
    logic [3:0]       in_rep;
    logic             abort;
    logic             dout;
    logic             dout_vld;
    logic             busy;
    logic             done;

    modport master (
        output in_valid, in_pat, in_rep, abort,
        input  in_ready, dout, dout_vld, busy, done
    );

    modport slave (
        input  in_valid, in_pat, in_rep, abort,
        output in_ready, dout, dout_vld, busy, done
    );
endinterface

// File: rtl/seq_tx.sv
// ---------------------------------------------------------------------------
// seq_tx : repeating serial pattern transmitter.
//
// Accepts a PAT_W-bit pattern plus a repeat count, then shifts the pattern
// out MSB first, (in_rep+1) times, with GAP idle cycles between repetitions.
// dout / dout_vld / done are registered and the first bit appears in the
// cycle right after the accepting edge.
//
// Ports:
//   clk   single clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   seq_tx_if.slave (request in, serial stream and status out)
//
// Parameters:
//   PAT_W pattern width, 2..16
//   GAP   idle cycles between repetitions, 0..15
// ---------------------------------------------------------------------------
module seq_tx #(
    parameter int PAT_W = 4,
    parameter int GAP   = 2
) (
    input  logic     clk,
    input  logic     rst,
    seq_tx_if.slave  bus
);
    localparam int              BW      = $clog2(PAT_W);
    localparam logic [BW-1:0]   BIT_MSB = BW'(PAT_W - 1);
    localparam logic [BW-1:0]   BIT_ONE = BW'(1);
    // Gap counter runs GAP-1 .. 0, so GAPW lasts exactly GAP cycles.
    localparam logic [3:0]      GAP_M1  = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAPW = 2'd2
    } state_t;

    // Registered state
    state_t           r_state;
    logic [PAT_W-1:0] r_pat;
    logic [BW-1:0]    r_bit;    // index of the bit currently on dout
    logic [3:0]       r_rep;    // repetitions still to send after this one
    logic [3:0]       r_gap;    // remaining gap cycles minus one
    logic             r_dout;
    logic             r_vld;
    logic             r_done;

    // Next-state values
    state_t           w_state_nxt;
    logic [PAT_W-1:0] w_pat_nxt;
    logic [BW-1:0]    w_bit_nxt;
    logic [3:0]       w_rep_nxt;
    logic [3:0]       w_gap_nxt;
    logic             w_dout_nxt;
    logic             w_vld_nxt;
    logic             w_done_nxt;
    logic [BW-1:0]    w_bit_dec;

    assign w_bit_dec = r_bit - BIT_ONE;

    // -----------------------------------------------------------------------
    // Next-state / next-output logic. Outputs are computed one cycle ahead
    // so the registered dout lines up with the state it belongs to.
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pat_nxt   = r_pat;
        w_bit_nxt   = r_bit;
        w_rep_nxt   = r_rep;
        w_gap_nxt   = r_gap;
        w_dout_nxt  = 1'b0;
        w_vld_nxt   = 1'b0;
        w_done_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                // abort is deliberately not looked at here
                if (bus.in_valid) begin
                    w_state_nxt = SEND;
                    w_pat_nxt   = bus.in_pat;
                    w_rep_nxt   = bus.in_rep;
                    w_bit_nxt   = BIT_MSB;
                    w_dout_nxt  = bus.in_pat[PAT_W-1];
                    w_vld_nxt   = 1'b1;
                end
            end

            SEND: begin
                if (bus.abort) begin
                    w_state_nxt = IDLE;
                    w_pat_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_rep_nxt   = '0;
                    w_gap_nxt   = '0;
                end else if (r_bit == '0) begin
                    // LSB is on the line this cycle
                    if (r_rep == 4'd0) begin
                        w_state_nxt = IDLE;
                        w_pat_nxt   = '0;
                    end else if (GAP > 0) begin
                        w_state_nxt = GAPW;
                        w_gap_nxt   = GAP_M1;
                    end else begin
                        // back-to-back repetition, no invalid cycle
                        w_bit_nxt   = BIT_MSB;
                        w_rep_nxt   = r_rep - 4'd1;
                        w_dout_nxt  = r_pat[PAT_W-1];
                        w_vld_nxt   = 1'b1;
                    end
                end else begin
                    w_bit_nxt   = w_bit_dec;
                    w_dout_nxt  = r_pat[w_bit_dec];
                    w_vld_nxt   = 1'b1;
                    // done rides with the LSB of the final repetition
                    w_done_nxt  = (r_bit == BIT_ONE) && (r_rep == 4'd0);
                end
            end

            GAPW: begin
                if (bus.abort) begin
                    w_state_nxt = IDLE;
                    w_pat_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_rep_nxt   = '0;
                    w_gap_nxt   = '0;
                end else if (r_gap == 4'd0) begin
                    w_state_nxt = SEND;
                    w_bit_nxt   = BIT_MSB;
                    w_rep_nxt   = r_rep - 4'd1;
                    w_dout_nxt  = r_pat[PAT_W-1];
                    w_vld_nxt   = 1'b1;
                end else begin
                    w_gap_nxt   = r_gap - 4'd1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_pat   <= '0;
            r_bit   <= '0;
            r_rep   <= '0;
            r_gap   <= '0;
            r_dout  <= 1'b0;
            r_vld   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pat   <= w_pat_nxt;
            r_bit   <= w_bit_nxt;
            r_rep   <= w_rep_nxt;
            r_gap   <= w_gap_nxt;
            r_dout  <= w_dout_nxt;
            r_vld   <= w_vld_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // in_ready drops combinationally with rst so nothing is offered while
    // the block is held in reset.
    assign bus.in_ready = (r_state == IDLE) && !rst;
    assign bus.busy     = (r_state != IDLE);
    assign bus.dout     = r_dout;
    assign bus.dout_vld = r_vld;
    assign bus.done     = r_done;

endmodule

// File: tb/tb_seq_tx.sv
// ---------------------------------------------------------------------------
// tb_seq_tx : self-checking bench for seq_tx.
// Two instances: u0 with GAP=2 and u1 with GAP=0, both PAT_W=4.
// Observation vector per cycle: {in_ready, busy, dout_vld, dout, done}.
// ---------------------------------------------------------------------------
module tb_seq_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_tx_if #(.PAT_W(4)) if0();
    seq_tx_if #(.PAT_W(4)) if1();

    seq_tx #(.PAT_W(4), .GAP(2)) u0 (.clk(clk), .rst(rst), .bus(if0));
    seq_tx #(.PAT_W(4), .GAP(0)) u1 (.clk(clk), .rst(rst), .bus(if1));

    int n_chk = 0;
    int n_err = 0;

    logic [4:0]  exp_q[$];
    logic [31:0] act_bits;
    int          act_nbusy;
    int          act_ndone;

    typedef struct {
        bit          sel;
        logic [3:0]  pat;
        logic [3:0]  rep;
        logic [31:0] exp_bits;
        int          exp_busy;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] obs(input bit sel);
        if (sel) return {if1.in_ready, if1.busy, if1.dout_vld, if1.dout, if1.done};
        else     return {if0.in_ready, if0.busy, if0.dout_vld, if0.dout, if0.done};
    endfunction

    task automatic drive(input bit sel, input logic v, input logic [3:0] pat,
                         input logic [3:0] rep, input logic ab);
        if0.in_valid = 1'b0; if0.abort = 1'b0;
        if1.in_valid = 1'b0; if1.abort = 1'b0;
        if (sel) begin
            if1.in_valid = v; if1.in_pat = pat; if1.in_rep = rep; if1.abort = ab;
        end else begin
            if0.in_valid = v; if0.in_pat = pat; if0.in_rep = rep; if0.abort = ab;
        end
    endtask

    // Reference: expected per-cycle observation of a whole frame, built from
    // the frame description (reps of MSB-first bits separated by gaps).
    task automatic build_exp(input logic [3:0] pat, input int rep, input int gap);
        exp_q.delete();
        for (int r = 0; r <= rep; r++) begin
            for (int b = 3; b >= 0; b--)
                exp_q.push_back({1'b0, 1'b1, 1'b1, pat[b], (r == rep && b == 0)});
            if (r < rep)
                for (int g = 0; g < gap; g++) exp_q.push_back(5'b01000);
        end
    endtask

    // Issues a request to an idle DUT and checks every cycle of the frame.
    // hold: keep in_valid high and scramble in_pat during the frame.
    // ab:   assert abort together with the request (must be ignored).
    task automatic run_frame(input bit sel, input logic [3:0] pat, input logic [3:0] rep,
                             input bit hold, input bit ab);
        int gap;
        gap = sel ? 0 : 2;
        build_exp(pat, int'(rep), gap);
        act_bits = '0; act_nbusy = 0; act_ndone = 0;
        chk("ready_before_req", 32'(obs(sel)), 32'b10000);
        drive(sel, 1'b1, pat, rep, ab);
        @(posedge clk); #1;
        if (!hold) drive(sel, 1'b0, pat, rep, 1'b0);
        else       drive(sel, 1'b1, 4'($urandom), 4'($urandom), 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [4:0] o;
            o = obs(sel);
            chk("frame_cycle", 32'(o), 32'(exp_q[i]));
            if (o[3]) act_nbusy++;
            if (o[2]) act_bits = {act_bits[30:0], o[1]};
            if (o[0]) act_ndone++;
            if (hold) drive(sel, 1'b1, 4'($urandom), 4'($urandom), 1'b0);
            @(posedge clk); #1;
        end
        chk("idle_after_frame", 32'(obs(sel)), 32'b10000);
        chk("busy_cycles", 32'(act_nbusy), 32'((int'(rep) + 1) * 4 + int'(rep) * gap));
        chk("done_pulses", 32'(act_ndone), 32'd1);
    endtask

    initial begin
        vec_t vecs[5];
        if0.in_valid = 0; if0.in_pat = 0; if0.in_rep = 0; if0.abort = 0;
        if1.in_valid = 0; if1.in_pat = 0; if1.in_rep = 0; if1.abort = 0;

        vecs[0] = '{0, 4'b1001, 4'd0, 32'b1001,         4};
        vecs[1] = '{0, 4'b1001, 4'd2, 32'b100110011001, 16};
        vecs[2] = '{1, 4'b1011, 4'd1, 32'b10111011,     8};
        vecs[3] = '{1, 4'b0110, 4'd0, 32'b0110,         4};
        vecs[4] = '{0, 4'b1100, 4'd1, 32'b11001100,     10};

        // reset state
        #1;
        chk("reset_u0", 32'(obs(0)), 32'b00000);
        chk("reset_u1", 32'(obs(1)), 32'b00000);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(obs(0)), 32'b10000);

        // fixed vectors
        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i].sel, vecs[i].pat, vecs[i].rep, 1'b0, 1'b0);
            chk("vec_bits", act_bits, vecs[i].exp_bits);
            chk("vec_busy", 32'(act_nbusy), 32'(vecs[i].exp_busy));
        end

        // in_valid held with changing in_pat: only the idle-edge value counts
        run_frame(0, 4'b1010, 4'd1, 1'b1, 1'b0);
        run_frame(0, 4'b0111, 4'd0, 1'b0, 1'b0);

        // abort while idle coincides with acceptance: request proceeds
        run_frame(0, 4'b1101, 4'd0, 1'b0, 1'b1);

        // abort during the 2nd bit of a 3-repetition frame
        drive(0, 1'b1, 4'b1010, 4'd2, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 4'b1010, 4'd2, 1'b0);
        chk("abort_bit1", 32'(obs(0)), 32'b01110);
        @(posedge clk); #1;
        chk("abort_bit2", 32'(obs(0)), 32'b01100);
        drive(0, 1'b0, 4'b1010, 4'd2, 1'b1);
        @(posedge clk); #1;
        drive(0, 1'b0, 4'b1010, 4'd2, 1'b0);
        chk("abort_next", 32'(obs(0)), 32'b10000);
        run_frame(0, 4'b0011, 4'd0, 1'b0, 1'b0);

        // asynchronous reset in the middle of SEND
        drive(0, 1'b1, 4'b1111, 4'd3, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 4'b1111, 4'd3, 1'b0);
        @(posedge clk); #1;
        chk("pre_rst_send", 32'(obs(0)), 32'b01110);
        #2 rst = 1'b1;
        #1;
        chk("rst_async", 32'(obs(0)), 32'b00000);
        @(posedge clk); #1;
        chk("rst_held", 32'(obs(0)), 32'b00000);
        rst = 1'b0;
        #1;
        chk("rst_release", 32'(obs(0)), 32'b10000);
        run_frame(0, 4'b1001, 4'd0, 1'b0, 1'b0);

        // randomized frames against the reference
        for (int k = 0; k < 24; k++) begin
            run_frame(1'($urandom), 4'($urandom), 4'($urandom_range(0, 15)),
                      1'($urandom), 1'($urandom_range(0, 3) == 0));
        end
        drive(0, 1'b0, 4'd0, 4'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
